// File: rtl/cache_port_pkg.sv
// Shared encodings for the cache refill / write-back port responder.
package cache_port_pkg;

  // Request type codes carried on rd_type / wr_type.
  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam int LINE_BEATS = 4;
  localparam int LINE_BYTES = 16;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_BEAT = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } wr_state_e;

  // Only the exact line code selects a 4-word transfer; every other code,
  // including the unused ones, is a single word.
  function automatic logic is_line(input logic [2:0] t);
    return t == TYPE_LINE;
  endfunction

endpackage

// File: rtl/cache_port_responder_if.sv
// Handshake bundle between the cache (master) and the memory responder (slave).
interface cache_port_responder_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         ret_stall;

  modport master (
    output rd_req, rd_type, rd_addr,
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output ret_stall,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );

  modport slave (
    input  rd_req, rd_type, rd_addr,
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  ret_stall,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );
endinterface

// File: rtl/cache_port_responder_mem.sv
// Word-addressed backing store: combinational read, line or byte-strobed write.
module resp_mem
  import cache_port_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic [MEM_AW-1:0] raddr,
  output logic [31:0]       rdata,
  input  logic              we,
  input  logic              wline,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [3:0]        wstrb,
  input  logic [127:0]      wdata
);

  logic [31:0] mem [2**MEM_AW];

  assign rdata = mem[raddr];

  // Line mode writes all four words of the aligned line; word mode merges bytes.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wline) begin
        for (int i = 0; i < LINE_BEATS; i++)
          mem[waddr | MEM_AW'(i)] <= wdata[32*i +: 32];
      end else begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/cache_port_responder.sv
// Memory-side responder for the cache refill / write-back port.
// One transaction in flight at a time; writes win over simultaneous reads.
module cache_port_responder
  import cache_port_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int RD_LAT = 2,   // 1..15
  parameter int WR_LAT = 2    // 1..15
) (
  input logic               clk,
  input logic               rst,
  cache_port_responder_if.slave bus
);

  // ---------------- state ----------------
  rd_state_e         r_state_q, r_state_d;
  logic [MEM_AW-1:0] r_base_q, r_base_d;
  logic [1:0]        r_idx_q, r_idx_d;
  logic              r_line_q, r_line_d;
  logic [3:0]        r_cnt_q, r_cnt_d;
  logic              ret_valid_q, ret_valid_d;
  logic              ret_last_q, ret_last_d;
  logic [31:0]       ret_data_q, ret_data_d;

  wr_state_e         w_state_q, w_state_d;
  logic [MEM_AW-1:0] w_addr_q, w_addr_d;
  logic              w_line_q, w_line_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic [127:0]      w_data_q, w_data_d;
  logic [3:0]        w_cnt_q, w_cnt_d;

  // ---------------- memory hookup ----------------
  logic [MEM_AW-1:0] mem_raddr;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [MEM_AW-1:0] ld_base;
  logic [1:0]        ld_idx;
  logic              ld_beat;

  logic [MEM_AW-1:0] rd_widx, wr_widx;
  logic              both_idle, rd_fire, wr_fire;

  // Upper address bits wrap away; byte offset within a word is irrelevant.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.rd_addr[31:MEM_AW+2], bus.rd_addr[1:0],
                              bus.wr_addr[31:MEM_AW+2], bus.wr_addr[1:0]};

  assign rd_widx   = bus.rd_addr[MEM_AW+1:2];
  assign wr_widx   = bus.wr_addr[MEM_AW+1:2];
  assign both_idle = (r_state_q == R_IDLE) && (w_state_q == W_IDLE);

  // Ready is held low during reset so nothing is accepted on the reset edge.
  assign bus.wr_rdy = both_idle & ~rst;
  assign bus.rd_rdy = both_idle & ~rst & ~bus.wr_req;
  assign wr_fire    = bus.wr_req & bus.wr_rdy;
  assign rd_fire    = bus.rd_req & bus.rd_rdy;

  // The stall hook masks the presented beat in the same cycle; the beat
  // stays parked in the output register until an unstalled cycle.
  assign bus.ret_valid = ret_valid_q & ~bus.ret_stall;
  assign bus.ret_last  = ret_last_q & ~bus.ret_stall;
  assign bus.ret_data  = ret_data_q;

  assign mem_raddr = ld_base | MEM_AW'(ld_idx);

  // Read FSM next state: count latency, then load one beat per unstalled cycle.
  always_comb begin
    r_state_d   = r_state_q;
    r_base_d    = r_base_q;
    r_idx_d     = r_idx_q;
    r_line_d    = r_line_q;
    r_cnt_d     = r_cnt_q;
    ret_valid_d = ret_valid_q;
    ret_last_d  = ret_last_q;
    ret_data_d  = ret_data_q;
    ld_base     = r_base_q;
    ld_idx      = r_idx_q;
    ld_beat     = 1'b0;

    case (r_state_q)
      R_IDLE: begin
        if (rd_fire) begin
          r_line_d = is_line(bus.rd_type);
          r_base_d = r_line_d ? {rd_widx[MEM_AW-1:2], 2'b00} : rd_widx;
          r_idx_d  = 2'd0;
          if (RD_LAT == 1) begin
            // No wait cycles: the first beat is registered on the accept edge.
            ld_base   = r_base_d;
            ld_idx    = 2'd0;
            ld_beat   = 1'b1;
            r_state_d = R_BEAT;
          end else begin
            r_cnt_d   = 4'(RD_LAT - 2);
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 4'd0) begin
          ld_idx    = 2'd0;
          ld_beat   = 1'b1;
          r_state_d = R_BEAT;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_BEAT: begin
        if (!bus.ret_stall) begin
          if (ret_last_q) begin
            ret_valid_d = 1'b0;
            ret_last_d  = 1'b0;
            r_state_d   = R_IDLE;
          end else begin
            ld_idx  = r_idx_q + 2'd1;
            r_idx_d = ld_idx;
            ld_beat = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    if (ld_beat) begin
      ret_valid_d = 1'b1;
      ret_data_d  = mem_rdata;
      ret_last_d  = !r_line_d || (ld_idx == 2'(LINE_BEATS - 1));
    end
  end

  // Write FSM next state: buffer the request, commit after WR_LAT busy cycles.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_line_d  = w_line_q;
    w_strb_d  = w_strb_q;
    w_data_d  = w_data_q;
    w_cnt_d   = w_cnt_q;
    mem_we    = 1'b0;

    case (w_state_q)
      W_IDLE: begin
        if (wr_fire) begin
          w_line_d  = is_line(bus.wr_type);
          w_addr_d  = w_line_d ? {wr_widx[MEM_AW-1:2], 2'b00} : wr_widx;
          w_strb_d  = bus.wr_wstrb;
          w_data_d  = bus.wr_data;
          w_cnt_d   = 4'(WR_LAT - 1);
          w_state_d = W_BUSY;
        end
      end
      W_BUSY: begin
        if (w_cnt_q == 4'd0) begin
          // A reset landing on the commit edge discards the write.
          mem_we    = ~rst;
          w_state_d = W_IDLE;
        end else begin
          w_cnt_d = w_cnt_q - 4'd1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Both FSMs and the registered return path; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q   <= R_IDLE;
      r_base_q    <= '0;
      r_idx_q     <= '0;
      r_line_q    <= 1'b0;
      r_cnt_q     <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
      w_state_q   <= W_IDLE;
      w_addr_q    <= '0;
      w_line_q    <= 1'b0;
      w_strb_q    <= '0;
      w_data_q    <= '0;
      w_cnt_q     <= '0;
    end else begin
      r_state_q   <= r_state_d;
      r_base_q    <= r_base_d;
      r_idx_q     <= r_idx_d;
      r_line_q    <= r_line_d;
      r_cnt_q     <= r_cnt_d;
      ret_valid_q <= ret_valid_d;
      ret_last_q  <= ret_last_d;
      ret_data_q  <= ret_data_d;
      w_state_q   <= w_state_d;
      w_addr_q    <= w_addr_d;
      w_line_q    <= w_line_d;
      w_strb_q    <= w_strb_d;
      w_data_q    <= w_data_d;
      w_cnt_q     <= w_cnt_d;
    end
  end

  resp_mem #(.MEM_AW(MEM_AW)) u_mem (
    .clk   (clk),
    .raddr (mem_raddr),
    .rdata (mem_rdata),
    .we    (mem_we),
    .wline (w_line_q),
    .waddr (w_addr_q),
    .wstrb (w_strb_q),
    .wdata (w_data_q)
  );

endmodule

// File: tb/tb_cache_port_responder.sv
// Bench for cache_port_responder: directed scenarios plus random traffic
// checked against a flat word-array model of the memory.
module tb_cache_port_responder;
  localparam int MEM_AW = 12;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;
  localparam logic [2:0] LINE = 3'b100;
  localparam logic [2:0] WORD = 3'b010;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_port_responder_if bus();

  cache_port_responder #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [0:4095];
  logic [31:0] beats [0:3];
  int last_wait;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 4096);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [2:0] t,
                                      input logic [3:0] s, input logic [127:0] d);
    int i;
    i = widx(a);
    if (t == LINE) begin
      for (int k = 0; k < 4; k++) ref_mem[i - (i % 4) + k] = d[32*k +: 32];
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic to_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] t,
                          input logic [3:0] s, input logic [127:0] d);
    bit ok = 0;
    bus.wr_req = 1; bus.wr_type = t; bus.wr_addr = a; bus.wr_wstrb = s; bus.wr_data = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.wr_rdy) begin ok = 1; break; end
      to_cycle();
    end
    chk("wr_accept", 32'(ok), 32'd1);
    if (!ok) begin bus.wr_req = 0; return; end
    to_cycle();
    // Scramble inputs after acceptance: only the accepted values may commit.
    bus.wr_req = 0; bus.wr_data = {4{$urandom}}; bus.wr_wstrb = 4'($urandom);
    bus.wr_addr = $urandom;
    for (int i = 1; i <= WR_LAT; i++) begin
      @(negedge clk);
      chk("wr_busy", 32'(bus.wr_rdy), 32'd0);
      to_cycle();
    end
    @(negedge clk);
    chk("wr_rdy_back", 32'(bus.wr_rdy), 32'd1);
    to_cycle();
    model_write(a, t, s, d);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] t,
                         input int stall_beat, input int stall_len, input string tag);
    int nb, got, stalled, base;
    bit ok = 0;
    logic [31:0] exp [0:3];
    nb = (t == LINE) ? 4 : 1;
    base = (t == LINE) ? widx(a) - (widx(a) % 4) : widx(a);
    for (int k = 0; k < nb; k++) exp[k] = ref_mem[base + k];
    bus.rd_req = 1; bus.rd_type = t; bus.rd_addr = a;
    last_wait = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.rd_rdy) begin ok = 1; break; end
      last_wait++;
      to_cycle();
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    if (!ok) begin bus.rd_req = 0; return; end
    to_cycle();
    bus.rd_req = 0; bus.rd_addr = $urandom; bus.rd_type = 3'($urandom);
    got = 0; stalled = 0;
    for (int cyc = 1; cyc <= 40 && got < nb; cyc++) begin
      bus.ret_stall = (stall_len > 0 && got == stall_beat && stalled < stall_len);
      @(negedge clk);
      if (bus.ret_stall) begin
        chk({tag, "_stalled_valid"}, 32'(bus.ret_valid), 32'd0);
        stalled++;
      end else if (bus.ret_valid) begin
        chk({tag, "_data"}, bus.ret_data, exp[got]);
        chk({tag, "_last"}, 32'(bus.ret_last), 32'(got == nb - 1));
        if (got == 0 && (stall_len == 0 || stall_beat != 0))
          chk({tag, "_latency"}, 32'(cyc), 32'(RD_LAT));
        beats[got] = bus.ret_data;
        got++;
      end else if (got > 0 || cyc >= RD_LAT) begin
        chk({tag, "_missing_beat"}, 32'(bus.ret_valid), 32'd1);
      end else begin
        chk({tag, "_early"}, 32'({bus.ret_valid, bus.ret_last}), 32'd0);
      end
      to_cycle();
    end
    bus.ret_stall = 0;
    chk({tag, "_beat_count"}, 32'(got), 32'(nb));
    @(negedge clk);
    chk({tag, "_after_valid"}, 32'(bus.ret_valid), 32'd0);
    chk({tag, "_after_rdy"}, 32'(bus.rd_rdy), 32'd1);
    to_cycle();
  endtask

  initial begin
    logic [31:0] saved [0:3];
    logic [127:0] d;
    logic [31:0] a;
    int seen;
    bit hit;

    bus.rd_req = 0; bus.rd_type = 0; bus.rd_addr = 0;
    bus.wr_req = 0; bus.wr_type = 0; bus.wr_addr = 0; bus.wr_wstrb = 0; bus.wr_data = 0;
    bus.ret_stall = 0;

    // Reset state.
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ret_valid", 32'(bus.ret_valid), 32'd0);
    chk("rst_ret_last", 32'(bus.ret_last), 32'd0);
    chk("rst_ret_data", bus.ret_data, 32'd0);
    chk("rst_rd_rdy", 32'(bus.rd_rdy), 32'd1);
    chk("rst_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    to_cycle();

    // Give words 0..127 known contents.
    for (int i = 0; i < 32; i++) do_write(32'(i * 16), LINE, 4'h0, {4{$urandom}});

    // Line write then line read from a mid-line address.
    do_write(32'h100, LINE, 4'h0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    do_read(32'h108, LINE, 0, 0, "line_rd");
    chk("line_b0", beats[0], 32'h11111111);
    chk("line_b1", beats[1], 32'h22222222);
    chk("line_b2", beats[2], 32'h33333333);
    chk("line_b3", beats[3], 32'h44444444);

    // Strobed word write then word read.
    do_write(32'h104, WORD, 4'b0011, {96'h0, 32'hAAAABBBB});
    do_read(32'h104, WORD, 0, 0, "strb_rd");
    chk("strb_word", beats[0], 32'h2222BBBB);

    // Simultaneous write and read: write goes first, read sees new data.
    d = {32'hD0D0D0D3, 32'hD0D0D0D2, 32'hD0D0D0D1, 32'hD0D0D0D0};
    bus.wr_req = 1; bus.wr_type = LINE; bus.wr_addr = 32'h100; bus.wr_data = d; bus.wr_wstrb = 0;
    bus.rd_req = 1; bus.rd_type = LINE; bus.rd_addr = 32'h100;
    @(negedge clk);
    chk("simul_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    chk("simul_rd_rdy", 32'(bus.rd_rdy), 32'd0);
    to_cycle();
    bus.wr_req = 0;
    for (int i = 1; i <= WR_LAT; i++) begin
      @(negedge clk);
      chk("simul_rd_blocked", 32'(bus.rd_rdy), 32'd0);
      to_cycle();
    end
    model_write(32'h100, LINE, 4'h0, d);
    do_read(32'h100, LINE, 0, 0, "simul_rd");
    chk("simul_rd_wait", 32'(last_wait), 32'd0);
    chk("simul_b0", beats[0], 32'hD0D0D0D0);
    chk("simul_b3", beats[3], 32'hD0D0D0D3);

    // Stall for three cycles starting at beat 2.
    do_read(32'h100, LINE, 2, 3, "stall_rd");

    // Reset during beat 2 of a line read.
    bus.rd_req = 1; bus.rd_type = LINE; bus.rd_addr = 32'h100;
    hit = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.rd_rdy) break;
      to_cycle();
    end
    to_cycle();
    bus.rd_req = 0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.ret_valid) seen++;
      if (seen == 3) begin hit = 1; rst = 1; break; end
      to_cycle();
    end
    chk("rstmid_beat2_seen", 32'(hit), 32'd1);
    to_cycle();
    rst = 0;
    @(negedge clk);
    chk("rstmid_valid", 32'(bus.ret_valid), 32'd0);
    chk("rstmid_last", 32'(bus.ret_last), 32'd0);
    to_cycle();
    @(negedge clk);
    chk("rstmid_rd_rdy", 32'(bus.rd_rdy), 32'd1);
    chk("rstmid_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    to_cycle();
    do_read(32'h100, LINE, 0, 0, "rstmid_reread");

    // Reset while a write is still busy: the write must not land.
    bus.wr_req = 1; bus.wr_type = LINE; bus.wr_addr = 32'h80; bus.wr_data = {4{32'hBADBAD00}};
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.wr_rdy) break;
      to_cycle();
    end
    to_cycle();
    bus.wr_req = 0;
    rst = 1;
    to_cycle();
    rst = 0;
    do_read(32'h80, LINE, 0, 0, "wr_discard");

    // Address wrap modulo memory size.
    do_read(32'h00010100, LINE, 0, 0, "wrap_hi");
    for (int k = 0; k < 4; k++) saved[k] = beats[k];
    do_read(32'h00000100, LINE, 0, 0, "wrap_lo");
    for (int k = 0; k < 4; k++) chk("wrap_match", beats[k], saved[k]);

    // Random traffic over the initialised region, any type code, random upper bits.
    for (int it = 0; it < 40; it++) begin
      a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, 3'($urandom), 4'($urandom), {4{$urandom}});
      else
        do_read(a, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), "rand_rd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_port_responder.md
Name: cache_port_responder

Overview:
- Synthesizable memory-side responder for the cache's line-refill and write-back port.
- Accepts read requests (line or word) and returns data beats with ret_valid/ret_last.
- Accepts write requests (full line or strobed word) into an internal word-addressed memory, with programmable latencies.
- Used as the memory model behind the cache in block-level simulation and FPGA bring-up, in place of the AXI bridge.

Parameters:
- MEM_AW, 12, word-address width of the internal memory (2^MEM_AW 32-bit words).
- RD_LAT, 2, cycles from read acceptance to the first return beat; legal range 1..15.
- WR_LAT, 2, cycles a write stays busy before it commits; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req  in  1  read request
- rd_type  in  3  3'b100 = line (4 beats); 3'b000/001/010 = single beat
- rd_addr  in  32  read byte address
- rd_rdy  out  1  read can be accepted this cycle
- ret_valid  out  1  return beat valid
- ret_last  out  1  final beat of the current read
- ret_data  out  32  return data
- wr_req  in  1  write request
- wr_type  in  3  3'b100 = line; 3'b000/001/010 = single word
- wr_addr  in  32  write byte address
- wr_wstrb  in  4  byte strobes; word writes only
- wr_data  in  128  line data, word 0 in [31:0]; word writes use [31:0]
- wr_rdy  out  1  write can be accepted this cycle
- ret_stall  in  1  test hook: suppresses beat emission this cycle

Behaviour:
- Interface is decided: clk is the clock; rst is synchronous, active-high.
- Reset values: ret_valid=0, ret_last=0, ret_data=0, both FSMs idle. rd_rdy and wr_rdy go high the first cycle after reset. Memory array is not reset.
- Address mapping: word index = addr[MEM_AW+1:2]; upper bits are ignored, so the address space wraps modulo memory size.
- Line operations force addr[3:2]=0. Beats and line words are in order 0..3.
- Handshake: a transfer is accepted on a clock edge where req & rdy. Requests may be held before acceptance; inputs are sampled only at acceptance.
- Ready rules:
  - wr_rdy = write FSM idle & read FSM idle.
  - rd_rdy = write FSM idle & read FSM idle & ~wr_req.
  - A simultaneous wr_req/rd_req therefore accepts the write first.
  - One outstanding transaction in total.
- Read FSM R_IDLE -> R_WAIT -> R_BEAT -> R_IDLE:
  - On acceptance in cycle T: capture base word index, beat count (4 or 1), and a latency counter.
  - First ret_valid appears in cycle T+RD_LAT.
  - Beats are consecutive unless ret_stall=1. A stalled cycle has ret_valid=0, and its beat is emitted on the next unstalled cycle.
  - ret_data, ret_valid and ret_last are registered. ret_last=1 only with the final beat. ret_data holds its value when ret_valid=0.
  - The cycle after the last beat, the FSM is in R_IDLE and rd_rdy may rise.
- Write FSM W_IDLE -> W_BUSY -> W_IDLE:
  - On acceptance in cycle T: capture address, type, strobes and data into the write buffer.
  - wr_rdy is low in cycles T+1..T+WR_LAT.
  - Memory commits at the edge ending cycle T+WR_LAT: line = 4 words in one cycle; word = per-byte merge with wr_wstrb.
  - wr_wstrb=0 on a word write commits nothing but still takes WR_LAT.
  - wr_rdy and rd_rdy may rise in cycle T+WR_LAT+1.
  - This gives read-after-write coherence with no forwarding path.
- Unsupported type codes (011, 101..111) are treated as single-beat/single-word.
- Reset mid-operation: any in-flight read is dropped (no further beats) and any uncommitted write is discarded. Committed memory is retained.

Decomposition:
- Shared package cache_port_pkg:
  - type encodings TYPE_BYTE=3'b000, TYPE_HALF=3'b001, TYPE_WORD=3'b010, TYPE_LINE=3'b100
  - LINE_BEATS=4, LINE_BYTES=16
  - read and write state encodings
- Sub-module resp_mem: 2^MEM_AW x 32 array.
  - One combinational read port.
  - One write port with a 4-word line mode and a byte-strobed word mode.
  - No reset.

Test Plan:
- Line write then line read, RD_LAT=2, WR_LAT=2: write 0x00000100 with {0x44444444,0x33333333,0x22222222,0x11111111}, accepted at T. Required: wr_rdy low T+1..T+2. Then a line read of 0x00000108 accepted at T' returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 in cycles T'+2..T'+5, with ret_last only in T'+5.
- Strobed word write: word 0x104 holds 0x22222222; write 0xAAAABBBB with wstrb 4'b0011 (rd_type=010). Required: word read of 0x104 returns a single beat 0x2222BBBB with ret_valid=ret_last=1.
- wr_req and rd_req asserted together on line 0x100. Required: the write is accepted first, rd_rdy stays 0 until the write commits, and the read returns the newly written data.
- Line read with ret_stall=1 for 3 cycles starting at beat 2. Required: ret_valid=0 during those cycles; exactly 4 beats in order 0..3; ret_last on the 4th beat only.
- rst pulsed during beat 2 of a line read. Required: next cycle ret_valid=0 and ret_last=0; rd_rdy=wr_rdy=1 the following cycle; re-reading the line returns the pre-reset contents.
- Wrap with MEM_AW=12: a read of 0x00010100 returns the same 4 beats as a read of 0x00000100.
